// File: rtl/ejtag_pkg.sv
// Shared definitions for the EJTAG drseg read path: FSM encoding, region codes,
// region base nibbles and select-vector bit positions.
package ejtag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_DONE = 3'd4
    } rd_state_t;

    typedef enum logic [2:0] {
        RG_DCR = 3'd0,
        RG_IB  = 3'd1,
        RG_DB  = 3'd2,
        RG_PB  = 3'd3,
        RG_SN  = 3'd4
    } region_t;

    localparam logic [3:0] BASE_DCR = 4'h0;
    localparam logic [3:0] BASE_IB  = 4'h1;
    localparam logic [3:0] BASE_DB  = 4'h2;
    localparam logic [3:0] BASE_PB  = 4'h3;

    localparam int SEL_W    = 7;
    localparam int SEL_DCR  = 0;
    localparam int SEL_IBS  = 1;
    localparam int SEL_IBRS = 2;
    localparam int SEL_DBS  = 3;
    localparam int SEL_DBRS = 4;
    localparam int SEL_PBS  = 5;
    localparam int SEL_PBRS = 6;

    function automatic region_t region_of(input logic [3:0] hi);
        case (hi)
            BASE_DCR: return RG_DCR;
            BASE_IB:  return RG_IB;
            BASE_DB:  return RG_DB;
            BASE_PB:  return RG_PB;
            default:  return RG_SN;
        endcase
    endfunction

endpackage

// File: rtl/ejtag_drseg_dec.sv
// Combinational drseg offset decoder: one-hot mux select plus an illegal-address
// flag. Shared between the read and write paths.
module ejtag_drseg_dec
    import ejtag_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  sel,
    output logic              err
);

    logic regbank;

    always_comb begin
        sel     = '0;
        // Nonzero ADDR[11:8] addresses the per-breakpoint register bank.
        regbank = |addr[11:8];
        case (region_of(addr[15:12]))
            RG_DCR: sel[SEL_DCR] = !regbank;
            RG_IB: begin
                sel[SEL_IBS]  = !regbank;
                sel[SEL_IBRS] = regbank;
            end
            RG_DB: begin
                sel[SEL_DBS]  = !regbank;
                sel[SEL_DBRS] = regbank;
            end
            RG_PB: begin
                sel[SEL_PBS]  = !regbank;
                sel[SEL_PBRS] = regbank;
            end
            default: sel = '0;
        endcase
    end

    // Outside 0x0000-0x3FFF, or DCR touched at anything but offset 0.
    assign err = (|addr[ADDR_W-1:14]) || ((addr[15:12] == BASE_DCR) && (|addr[11:0]));

endmodule

// File: rtl/ejtag_drseg_rd_ctl.sv
// Round-robin read sequencer between probe and DMA for the drseg data-out mux.
// Optional build macro EJRC_ADDR_ERR_EN adds EJRC_RD_ERR and an error fast path.
module ejtag_drseg_rd_ctl
    import ejtag_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic              CORE_CLOCK,
    input  logic              RESET_D1_R_N,
    input  logic              EJRC_PRB_REQ,
    input  logic [ADDR_W-1:0] EJRC_PRB_ADDR,
    input  logic              EJRC_DMA_REQ,
    input  logic [ADDR_W-1:0] EJRC_DMA_ADDR,
    input  logic [31:0]       EJDO_DATA,
    output logic              EJRC_SELDCR,
    output logic              EJRC_SELIBS,
    output logic              EJRC_SELIBRS,
    output logic              EJRC_SELDBS,
    output logic              EJRC_SELDBRS,
    output logic              EJRC_SELPBS,
    output logic              EJRC_SELPBRS,
    output logic              EJRC_SELPROBE,
    output logic              EJRC_PRB_DONE,
    output logic              EJRC_DMA_DONE,
    output logic [31:0]       EJRC_RD_DATA,
    output logic              EJRC_BUSY
`ifdef EJRC_ADDR_ERR_EN
    ,
    output logic              EJRC_RD_ERR
`endif
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    rd_state_t         state_reg;
    logic              grant_prb_reg;
    logic              last_prb_reg;
    logic [3:0]        wait_cnt_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic              selprobe_reg;
    logic              prb_done_reg;
    logic              dma_done_reg;
    logic [31:0]       rd_data_reg;

    logic              win_prb;
    logic [ADDR_W-1:0] win_addr;
    logic [SEL_W-1:0]  dec_sel;
    logic              dec_err;

    // Probe wins unless DMA also asks and the probe had the previous grant.
    assign win_prb  = EJRC_PRB_REQ && !(EJRC_DMA_REQ && last_prb_reg);
    assign win_addr = win_prb ? EJRC_PRB_ADDR : EJRC_DMA_ADDR;

    ejtag_drseg_dec #(.ADDR_W(ADDR_W)) u_dec (
        .addr (win_addr),
        .sel  (dec_sel),
        .err  (dec_err)
    );

`ifdef EJRC_ADDR_ERR_EN
    logic err_pend_reg;
    logic rd_err_reg;
    assign EJRC_RD_ERR = rd_err_reg;
`else
    logic unused_dec_err;
    assign unused_dec_err = dec_err;
`endif

    always_ff @(posedge CORE_CLOCK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) begin
            state_reg     <= ST_IDLE;
            grant_prb_reg <= 1'b0;
            last_prb_reg  <= 1'b0;
            wait_cnt_reg  <= '0;
            sel_reg       <= '0;
            selprobe_reg  <= 1'b0;
            prb_done_reg  <= 1'b0;
            dma_done_reg  <= 1'b0;
            rd_data_reg   <= '0;
`ifdef EJRC_ADDR_ERR_EN
            err_pend_reg  <= 1'b0;
            rd_err_reg    <= 1'b0;
`endif
        end else begin
            prb_done_reg <= 1'b0;
            dma_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (EJRC_PRB_REQ || EJRC_DMA_REQ) begin
                        grant_prb_reg <= win_prb;
                        last_prb_reg  <= win_prb;
`ifdef EJRC_ADDR_ERR_EN
                        err_pend_reg  <= dec_err;
                        if (dec_err) begin
                            state_reg <= ST_CAPT;
                        end else begin
                            sel_reg      <= dec_sel;
                            selprobe_reg <= win_prb;
                            state_reg    <= ST_SEL;
                        end
`else
                        sel_reg      <= dec_sel;
                        selprobe_reg <= win_prb;
                        state_reg    <= ST_SEL;
`endif
                    end
                end
                ST_SEL: begin
                    wait_cnt_reg <= WAIT_LD;
                    if (WAIT_CYC == 0) begin
                        sel_reg      <= '0;
                        selprobe_reg <= 1'b0;
                        state_reg    <= ST_CAPT;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    if (wait_cnt_reg == 4'd1) begin
                        sel_reg      <= '0;
                        selprobe_reg <= 1'b0;
                        state_reg    <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    // The mux registered our selects on the edge entering this state.
`ifdef EJRC_ADDR_ERR_EN
                    rd_data_reg <= err_pend_reg ? 32'd0 : EJDO_DATA;
                    rd_err_reg  <= err_pend_reg;
`else
                    rd_data_reg <= EJDO_DATA;
`endif
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    prb_done_reg <= grant_prb_reg;
                    dma_done_reg <= !grant_prb_reg;
                    state_reg    <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign EJRC_SELDCR   = sel_reg[SEL_DCR];
    assign EJRC_SELIBS   = sel_reg[SEL_IBS];
    assign EJRC_SELIBRS  = sel_reg[SEL_IBRS];
    assign EJRC_SELDBS   = sel_reg[SEL_DBS];
    assign EJRC_SELDBRS  = sel_reg[SEL_DBRS];
    assign EJRC_SELPBS   = sel_reg[SEL_PBS];
    assign EJRC_SELPBRS  = sel_reg[SEL_PBRS];
    assign EJRC_SELPROBE = selprobe_reg;
    assign EJRC_PRB_DONE = prb_done_reg;
    assign EJRC_DMA_DONE = dma_done_reg;
    assign EJRC_RD_DATA  = rd_data_reg;
    assign EJRC_BUSY     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ejtag_drseg_rd_ctl.sv
// Bench for ejtag_drseg_rd_ctl: instance 0 has no wait cycles, instance 1 has three.
// A timeline model predicts every output each cycle; directed tests pin it with literals.
module tb_ejtag_drseg_rd_ctl;

    localparam logic [31:0] SNOOP = 32'h1234_5678;

    logic clk;
    logic rst_n;
    logic        prb_req  [2];
    logic [15:0] prb_addr [2];
    logic        dma_req  [2];
    logic [15:0] dma_addr [2];
    logic [31:0] ejdo     [2];
    logic [31:0] src      [7];

    wire [6:0]  sel0, sel1;
    wire        sp0, sp1, pd0, pd1, dd0, dd1, bz0, bz1;
    wire [31:0] rd0, rd1;
    wire [6:0]  sel_w [2];
    wire        sp_w [2], pd_w [2], dd_w [2], bz_w [2];
    wire [31:0] rd_w [2];
    assign sel_w[0] = sel0; assign sel_w[1] = sel1;
    assign sp_w[0]  = sp0;  assign sp_w[1]  = sp1;
    assign pd_w[0]  = pd0;  assign pd_w[1]  = pd1;
    assign dd_w[0]  = dd0;  assign dd_w[1]  = dd1;
    assign bz_w[0]  = bz0;  assign bz_w[1]  = bz1;
    assign rd_w[0]  = rd0;  assign rd_w[1]  = rd1;
`ifdef EJRC_ADDR_ERR_EN
    wire er0, er1;
    wire er_w [2];
    assign er_w[0] = er0; assign er_w[1] = er1;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ejtag_drseg_rd_ctl #(.ADDR_W(16), .WAIT_CYC(0)) dut0 (
        .CORE_CLOCK(clk), .RESET_D1_R_N(rst_n),
        .EJRC_PRB_REQ(prb_req[0]), .EJRC_PRB_ADDR(prb_addr[0]),
        .EJRC_DMA_REQ(dma_req[0]), .EJRC_DMA_ADDR(dma_addr[0]),
        .EJDO_DATA(ejdo[0]),
        .EJRC_SELDCR(sel0[0]), .EJRC_SELIBS(sel0[1]), .EJRC_SELIBRS(sel0[2]),
        .EJRC_SELDBS(sel0[3]), .EJRC_SELDBRS(sel0[4]), .EJRC_SELPBS(sel0[5]),
        .EJRC_SELPBRS(sel0[6]), .EJRC_SELPROBE(sp0),
        .EJRC_PRB_DONE(pd0), .EJRC_DMA_DONE(dd0),
        .EJRC_RD_DATA(rd0), .EJRC_BUSY(bz0)
`ifdef EJRC_ADDR_ERR_EN
        , .EJRC_RD_ERR(er0)
`endif
    );

    ejtag_drseg_rd_ctl #(.ADDR_W(16), .WAIT_CYC(3)) dut1 (
        .CORE_CLOCK(clk), .RESET_D1_R_N(rst_n),
        .EJRC_PRB_REQ(prb_req[1]), .EJRC_PRB_ADDR(prb_addr[1]),
        .EJRC_DMA_REQ(dma_req[1]), .EJRC_DMA_ADDR(dma_addr[1]),
        .EJDO_DATA(ejdo[1]),
        .EJRC_SELDCR(sel1[0]), .EJRC_SELIBS(sel1[1]), .EJRC_SELIBRS(sel1[2]),
        .EJRC_SELDBS(sel1[3]), .EJRC_SELDBRS(sel1[4]), .EJRC_SELPBS(sel1[5]),
        .EJRC_SELPBRS(sel1[6]), .EJRC_SELPROBE(sp1),
        .EJRC_PRB_DONE(pd1), .EJRC_DMA_DONE(dd1),
        .EJRC_RD_DATA(rd1), .EJRC_BUSY(bz1)
`ifdef EJRC_ADDR_ERR_EN
        , .EJRC_RD_ERR(er1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Registered data-out mux: each source has its own value, no select reads snoop.
    function automatic logic [31:0] mux_of(input logic [6:0] s);
        logic [31:0] v;
        v = '0;
        if (s == 7'd0) return SNOOP;
        for (int b = 0; b < 7; b++) if (s[b]) v = v | src[b];
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        ejdo[0] <= mux_of(sel0);
        ejdo[1] <= mux_of(sel1);
    end

    // ---------------- behavioural model ----------------
    int        wc       [2] = '{0, 3};
    int        m_t      [2] = '{-1, -1};   // edges since the request was accepted
    int        m_len    [2] = '{3, 3};     // edge index at which DONE appears
    bit        m_prb    [2] = '{0, 0};
    bit        m_last   [2] = '{0, 0};
    int        m_bit    [2] = '{-1, -1};
    bit        m_err    [2] = '{0, 0};
    logic [31:0] m_rd   [2] = '{32'd0, 32'd0};
    bit        m_rd_err [2] = '{0, 0};

    function automatic int sel_bit_of(input int a);
        int r, lo;
        r  = a / 4096;
        lo = a % 4096;
        if (r == 0) return (lo < 256) ? 0 : -1;
        if (r >= 1 && r <= 3) return 2 * r - 1 + ((lo >= 256) ? 1 : 0);
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_t[k] = -1; m_last[k] = 0; m_rd[k] = 0; m_rd_err[k] = 0; m_err[k] = 0;
            end else begin
                int a;
                if (m_t[k] == m_len[k]) m_t[k] = -1;
                if (m_t[k] >= 0) begin
                    m_t[k]++;
                end else if (prb_req[k] || dma_req[k]) begin
                    m_prb[k]  = prb_req[k] && !(dma_req[k] && m_last[k]);
                    m_last[k] = m_prb[k];
                    a = m_prb[k] ? int'(prb_addr[k]) : int'(dma_addr[k]);
                    m_bit[k] = sel_bit_of(a);
`ifdef EJRC_ADDR_ERR_EN
                    m_err[k] = (a >= 16384) || (a > 0 && a < 4096);
`else
                    m_err[k] = 0;
`endif
                    m_len[k] = m_err[k] ? 2 : wc[k] + 3;
                    m_t[k] = 0;
                end
                if (m_t[k] >= 0 && m_t[k] == m_len[k] - 1) begin
                    m_rd[k]     = m_err[k] ? 32'd0 : ((m_bit[k] < 0) ? SNOOP : src[m_bit[k]]);
                    m_rd_err[k] = m_err[k];
                end
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    initial begin
        bit         ins, dn;
        logic [6:0] es;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ins = (m_t[k] >= 0) && (m_t[k] <= m_len[k] - 3) && !m_err[k];
                es  = (ins && m_bit[k] >= 0) ? 7'(1 << m_bit[k]) : 7'd0;
                dn  = (m_t[k] >= 0) && (m_t[k] == m_len[k]);
                chk($sformatf("sel%0d", k), 32'(sel_w[k]), 32'(es));
                chk($sformatf("selprobe%0d", k), 32'(sp_w[k]), 32'(ins && m_prb[k]));
                chk($sformatf("busy%0d", k), 32'(bz_w[k]), 32'((m_t[k] >= 0) && (m_t[k] < m_len[k])));
                chk($sformatf("prb_done%0d", k), 32'(pd_w[k]), 32'(dn && m_prb[k]));
                chk($sformatf("dma_done%0d", k), 32'(dd_w[k]), 32'(dn && !m_prb[k]));
                chk($sformatf("rd_data%0d", k), rd_w[k], m_rd[k]);
`ifdef EJRC_ADDR_ERR_EN
                chk($sformatf("rd_err%0d", k), 32'(er_w[k]), 32'(m_rd_err[k]));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic txn(input int k, input bit is_prb, input logic [15:0] a,
                       output int lat, output int selc, output int spc);
        int n;
        @(posedge clk); #2;
        if (is_prb) begin prb_req[k] = 1'b1; prb_addr[k] = a; end
        else        begin dma_req[k] = 1'b1; dma_addr[k] = a; end
        n = cyc + 1;
        lat = -1; selc = 0; spc = 0;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            @(negedge clk);
            if (sel_w[k] != 7'd0) selc++;
            if (sp_w[k]) spc++;
            if ((is_prb && pd_w[k]) || (!is_prb && dd_w[k])) begin
                lat = cyc - n + 1;
                prb_req[k] = 1'b0;
                dma_req[k] = 1'b0;
            end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL txn_timeout inst%0d addr %h: no DONE within 60 cycles", k, a);
            prb_req[k] = 1'b0;
            dma_req[k] = 1'b0;
        end
    endtask

    task automatic tie_round(input int idx, input bit want_prb);
        bit got, seen;
        got = 0; seen = 0;
        @(posedge clk); #2;
        prb_req[0] = 1'b1; prb_addr[0] = 16'h1000;
        dma_req[0] = 1'b1; dma_addr[0] = 16'h3100;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (pd_w[0] || dd_w[0]) begin
                seen = 1; got = pd_w[0];
                prb_req[0] = 1'b0; dma_req[0] = 1'b0;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL tie_timeout round %0d: no DONE within 60 cycles", idx);
            prb_req[0] = 1'b0; dma_req[0] = 1'b0;
        end else begin
            chk($sformatf("tie_grant_prb_r%0d", idx), 32'(got), 32'(want_prb));
            chk($sformatf("tie_rd_r%0d", idx), rd0, want_prb ? 32'h1B51_0011 : 32'h9B56_0016);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, selc, spc, dn, bc;
        src[0] = 32'hA5A5_0001; src[1] = 32'h1B51_0011; src[2] = 32'h1B52_0012;
        src[3] = 32'hDB53_0013; src[4] = 32'hDB54_0014; src[5] = 32'h9B55_0015;
        src[6] = 32'h9B56_0016;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            prb_req[k] = 1'b0; dma_req[k] = 1'b0;
            prb_addr[k] = '0; dma_addr[k] = '0; ejdo[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bz0), 32'd0);
        chk("reset_sel", 32'(sel0), 32'd0);
        chk("reset_rd", rd0, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Probe DCR read with no wait cycles
        txn(0, 1'b1, 16'h0000, lat, selc, spc);
        chk("dcr_latency", 32'(lat), 32'd4);
        chk("dcr_sel_cycles", 32'(selc), 32'd1);
        chk("dcr_selprobe_cycles", 32'(spc), 32'd1);
        chk("dcr_rd", rd0, 32'hA5A5_0001);

        // DMA DBRS read with three wait cycles
        txn(1, 1'b0, 16'h2104, lat, selc, spc);
        chk("dbrs_latency", 32'(lat), 32'd7);
        chk("dbrs_sel_cycles", 32'(selc), 32'd4);
        chk("dbrs_selprobe_cycles", 32'(spc), 32'd0);
        chk("dbrs_rd", rd1, 32'hDB54_0014);

        // Unmapped region
        txn(0, 1'b1, 16'h5000, lat, selc, spc);
        chk("snoop_sel_cycles", 32'(selc), 32'd0);
`ifdef EJRC_ADDR_ERR_EN
        chk("snoop_latency", 32'(lat), 32'd3);
        chk("snoop_rd", rd0, 32'd0);
        chk("snoop_err", 32'(er0), 32'd1);
`else
        chk("snoop_latency", 32'(lat), 32'd4);
        chk("snoop_rd", rd0, 32'h1234_5678);
`endif

        // Request withdrawn during SEL still completes exactly once
        @(posedge clk); #2;
        prb_req[0] = 1'b1; prb_addr[0] = 16'h2000;
        @(posedge clk); #2;
        prb_req[0] = 1'b0;
        dn = 0; bc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pd0) dn++;
            if (bz0) bc++;
        end
        chk("drop_done_count", 32'(dn), 32'd1);
        chk("drop_busy_cycles", 32'(bc), 32'd3);
        chk("drop_rd", rd0, 32'hDB53_0013);

        // Reset asserted while instance 1 is in WAIT
        @(posedge clk); #2;
        prb_req[1] = 1'b1; prb_addr[1] = 16'h3000;
        repeat (3) @(posedge clk);
        #3;
        chk("prerst_busy", 32'(bz1), 32'd1);
        chk("prerst_sel", 32'(sel1), 32'h20);
        rst_n = 1'b0;
        #1;
        chk("rst_sel_drop", 32'(sel1), 32'd0);
        chk("rst_busy_drop", 32'(bz1), 32'd0);
        chk("rst_selprobe_drop", 32'(sp1), 32'd0);
        prb_req[1] = 1'b0;
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (pd1 || dd1) dn++;
        end
        chk("rst_no_done", 32'(dn), 32'd0);
        @(posedge clk); #4;
        rst_n = 1'b1;

        // Simultaneous requests: probe first after reset, then alternate
        tie_round(0, 1'b1);
        tie_round(1, 1'b0);
        tie_round(2, 1'b1);
        tie_round(3, 1'b0);

        // Instance 1 recovers and completes a normal probe read
        txn(1, 1'b1, 16'h3000, lat, selc, spc);
        chk("post_rst_latency", 32'(lat), 32'd7);
        chk("post_rst_sel_cycles", 32'(selc), 32'd4);
        chk("post_rst_selprobe_cycles", 32'(spc), 32'd4);
        chk("post_rst_rd", rd1, 32'h9B55_0015);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ejtag_drseg_rd_ctl.md
Name: ejtag_drseg_rd_ctl

Overview:
Read sequencer and arbiter in front of the EJTAG drseg data-out mux. Two requesters share the one read path: the probe (TAP processor access) and the EJTAG DMA engine. The block decodes each request address into one-hot mux selects, waits for the registered mux output, captures it and returns it to the granted requester. It guarantees that at most one select group is active at a time.

Parameters:
ADDR_W, 16, drseg offset width (byte address)
WAIT_CYC, 0, extra select-hold cycles before capture (0..15) for slow register sources

Ports:
CORE_CLOCK  in  1  core clock
RESET_D1_R_N  in  1  reset; asynchronous assert, active-low
EJRC_PRB_REQ  in  1  probe read request; level, held until EJRC_PRB_DONE
EJRC_PRB_ADDR  in  ADDR_W  probe drseg offset; stable while REQ high
EJRC_DMA_REQ  in  1  DMA read request (EJC_DMAACC side); level
EJRC_DMA_ADDR  in  ADDR_W  DMA drseg offset
EJDO_DATA  in  32  registered mux output
EJRC_SELDCR, EJRC_SELIBS, EJRC_SELIBRS, EJRC_SELDBS, EJRC_SELDBRS, EJRC_SELPBS, EJRC_SELPBRS  out  1 each  mux selects, registered
EJRC_SELPROBE  out  1  high while the granted requester is the probe
EJRC_PRB_DONE  out  1  one-cycle pulse; EJRC_RD_DATA valid
EJRC_DMA_DONE  out  1  one-cycle pulse; EJRC_RD_DATA valid
EJRC_RD_DATA  out  32  captured read data; held until next capture
EJRC_BUSY  out  1  FSM not IDLE

Behaviour:
- Reset values: all selects 0, SELPROBE 0, DONE pulses 0, RD_DATA 0, BUSY 0, FSM IDLE, last-grant = DMA (probe wins the first tie).
- Address decode uses ADDR[15:12] and ADDR[11:8]:
  - 0x0: ADDR[11:8]==0 gives DCR.
  - 0x1: ADDR[11:8]==0 gives IBS, otherwise IBRS.
  - 0x2: same split, DBS / DBRS.
  - 0x3: same split, PBS / PBRS.
  - Anything else: no select, which reads snoop data.
- FSM states: IDLE -> SEL -> WAIT -> CAPT -> DONE -> IDLE.
- IDLE:
  - If any REQ is high, arbitrate round-robin: a single requester is granted; on a tie, the requester not granted last wins.
  - Latch the grant and address; next state SEL.
- SEL:
  - The decoded select (at most one) and SELPROBE are registered high for this cycle and all of WAIT.
  - Load the wait counter with WAIT_CYC. Go to WAIT if WAIT_CYC>0, else to CAPT.
- WAIT: decrement the counter; at 0, go to CAPT.
- CAPT:
  - EJDO_DATA reflects the selects from the previous edge; load it into RD_DATA.
  - Deassert all selects.
- DONE:
  - Pulse the DONE of the granted requester for exactly one cycle, then return to IDLE.
  - The requester drops REQ on the DONE cycle. A REQ still high in IDLE is a new request.
- Latency at WAIT_CYC=0: REQ sampled at edge N gives DONE high in cycle N+4.
- Selects are never asserted outside SEL/WAIT. A grant cannot change mid-transaction; a REQ arriving while BUSY waits.
- A requester deasserting REQ mid-transaction does not abort the transaction; it completes and DONE still pulses.
- Asynchronous reset mid-transaction: everything returns to reset values at once, with no DONE pulse.
- Simultaneous REQs at reset release: the probe is granted.

Optional Feature:
EJRC_ADDR_ERR_EN
- Defined: adds output EJRC_RD_ERR (1 bit, reset 0), valid with DONE.
  - An address outside 0x0000-0x3FFF, or a DCR address with a nonzero ADDR[11:0], sets RD_ERR=1.
  - The erroring access skips SEL/WAIT (no select asserted) and RD_DATA is loaded with 0.
- Undefined: no port; such addresses read snoop data through the normal path.

Decomposition:
- Shared package (ejtag_pkg):
  - FSM state encoding.
  - Region codes (DCR, IB, DB, PB, SN).
  - Region base constants 0x0, 0x1, 0x2, 0x3.
  - The 7-bit select vector bit positions.
- One natural sub-module: ejtag_drseg_dec, a combinational address-to-one-hot select decoder, reused by the write path later.

Test Plan:
- Probe only, WAIT_CYC=0, ADDR=0x0000, EJDO_DATA driven 0xA5A5_0001 after SELDCR -> SELDCR high 1 cycle; PRB_DONE at N+4; RD_DATA=0xA5A5_0001; SELPROBE high during SEL.
- PRB and DMA both request at the same edge, repeated 4 times -> grants P, D, P, D; never two selects high; DONE pulses alternate.
- WAIT_CYC=3, DMA ADDR=0x2104 -> SELDBRS high for 4 cycles; DMA_DONE at N+7; SELPROBE 0 throughout.
- ADDR=0x5000 -> no select asserted; RD_DATA = snoop value 0x1234_5678. With EJRC_ADDR_ERR_EN: RD_ERR=1 and RD_DATA=0.
- RESET_D1_R_N pulled low in WAIT -> selects and BUSY drop immediately; no DONE; after release a new probe request completes normally.
- REQ dropped during SEL -> transaction still completes with one DONE pulse; no second grant.
